// File: rtl/debug_slave_cmd_queue.sv
// System-clock-side JTAG debug command receiver: resynchronises the virtual-JTAG
// update strobes, latches IR, and queues {ir, sr} captures in a show-ahead FIFO.
module debug_slave_cmd_queue #(
    parameter int IR_W       = 2,
    parameter int DR_W       = 38,
    parameter int DEPTH      = 4,
    parameter int SYNC_DEPTH = 2,
    parameter int ACT_BIT    = 34
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     vs_uir,
    input  logic                     vs_udr,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [DR_W-1:0]          sr,
    input  logic                     cmd_ready,
    input  logic                     ovf_clr,
    output logic                     cmd_valid,
    output logic [IR_W-1:0]          cmd_ir,
    output logic [DR_W-1:0]          cmd_data,
    output logic                     cmd_action,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = IR_W + DR_W;

    logic [SYNC_DEPTH-1:0] uir_sync_q, uir_sync_d;
    logic [SYNC_DEPTH-1:0] udr_sync_q, udr_sync_d;
    logic                  uir_hist_q, uir_hist_d;
    logic                  udr_hist_q, udr_hist_d;
    logic [IR_W-1:0]       ir_reg_q, ir_reg_d;
    logic [EW-1:0]         mem_q [DEPTH];
    logic [EW-1:0]         mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d;

    logic                  uir_p, udr_p;
    logic                  full, pop, push_ok, push_drop;
    logic [IR_W-1:0]       ir_sel;

    // Handshake: an entry leaves the queue on any clk edge where cmd_valid && cmd_ready;
    // cmd_valid depends only on registered occupancy, never on cmd_ready.
    always_comb begin
        uir_sync_d = {uir_sync_q[SYNC_DEPTH-2:0], vs_uir};
        udr_sync_d = {udr_sync_q[SYNC_DEPTH-2:0], vs_udr};
        uir_hist_d = uir_sync_q[SYNC_DEPTH-1];
        udr_hist_d = udr_sync_q[SYNC_DEPTH-1];
        uir_p      = uir_sync_q[SYNC_DEPTH-1] & ~uir_hist_q;
        udr_p      = udr_sync_q[SYNC_DEPTH-1] & ~udr_hist_q;

        // A coinciding IR update must already apply to the data being captured.
        ir_sel   = uir_p ? ir_in : ir_reg_q;
        ir_reg_d = ir_sel;

        full      = (level_q == LW'(DEPTH));
        pop       = (level_q != '0) && cmd_ready;
        push_ok   = udr_p && (!full || pop);
        push_drop = udr_p && full && !pop;

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = {ir_sel, sr};
        end
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);

        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push_ok && pop) begin
            level_d = level_q - LW'(1);
        end

        ovf_d = ovf_q;
        if (push_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            uir_hist_q <= 1'b0;
            udr_hist_q <= 1'b0;
            ir_reg_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            uir_sync_q <= uir_sync_d;
            udr_sync_q <= udr_sync_d;
            uir_hist_q <= uir_hist_d;
            udr_hist_q <= udr_hist_d;
            ir_reg_q   <= ir_reg_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
        end
    end

    assign cmd_valid          = (level_q != '0);
    assign {cmd_ir, cmd_data} = mem_q[rd_ptr_q];
    assign cmd_action         = cmd_data[ACT_BIT];
    assign level              = level_q;
    assign ovf                = ovf_q;

endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// Directed bench for debug_slave_cmd_queue: strobe latency, fill/overflow,
// concurrent pop, coincident IR/DR update, wrap-around and async reset.
module tb_debug_slave_cmd_queue;

    localparam int IR_W = 2;
    localparam int DR_W = 38;
    localparam int DEPTH = 4;
    localparam int SYNC_DEPTH = 2;
    localparam int ACT_BIT = 34;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            vs_uir, vs_udr;
    logic [IR_W-1:0] ir_in;
    logic [DR_W-1:0] sr;
    logic            cmd_ready, ovf_clr;
    logic            cmd_valid;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_data;
    logic            cmd_action;
    logic [2:0]      level;
    logic            ovf;

    int vectors = 0;
    int miscompares = 0;
    int popped = 0;

    logic [IR_W+DR_W-1:0] exp_q[$];
    logic [IR_W-1:0]      model_ir = '0;
    logic                 model_ovf = 1'b0;

    debug_slave_cmd_queue #(
        .IR_W(IR_W), .DR_W(DR_W), .DEPTH(DEPTH), .SYNC_DEPTH(SYNC_DEPTH), .ACT_BIT(ACT_BIT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
        .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .cmd_action(cmd_action), .level(level), .ovf(ovf)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_head(input string tag);
        logic [IR_W+DR_W-1:0] e;
        check({tag, "_valid"}, 64'(cmd_valid), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_model_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q[0];
            check({tag, "_ir"},     64'(cmd_ir),     64'(e[IR_W+DR_W-1:DR_W]));
            check({tag, "_data"},   64'(cmd_data),   64'(e[DR_W-1:0]));
            check({tag, "_action"}, 64'(cmd_action), 64'(e[ACT_BIT]));
        end
    endtask

    // Called at a negedge; the pop happens at the following posedge.
    task automatic pop_one(input string tag);
        chk_head(tag);
        cmd_ready = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    // Strobe high 3 periods, low 4; the push edge is the 3rd posedge after raising.
    task automatic strobe(input logic do_uir, input logic do_udr, input logic [IR_W-1:0] ir,
                          input logic [DR_W-1:0] data, input logic pop_at_push);
        if (do_uir) begin
            ir_in    = ir;
            model_ir = ir;
        end
        if (do_udr) sr = data;
        vs_uir = do_uir;
        vs_udr = do_udr;
        @(negedge clk);
        @(negedge clk);
        if (pop_at_push) begin
            chk_head("cpop");
            cmd_ready = 1'b1;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (do_udr) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({model_ir, data});
            else model_ovf = 1'b1;
        end
        @(negedge clk);
        if (pop_at_push) cmd_ready = 1'b0;
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; vs_uir = 1'b0; vs_udr = 1'b0; ir_in = '0; sr = '0;
        cmd_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid",  64'(cmd_valid),  64'd0);
        check("rst_level",  64'(level),      64'd0);
        check("rst_ovf",    64'(ovf),        64'd0);
        check("rst_ir",     64'(cmd_ir),     64'd0);
        check("rst_data",   64'(cmd_data),   64'd0);
        check("rst_action", 64'(cmd_action), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // single command with latency check
        strobe(1'b1, 1'b0, 2'b01, '0, 1'b0);
        sr = 38'h04_0000_1234;
        vs_udr = 1'b1;
        @(negedge clk); check("lat_e0", 64'(cmd_valid), 64'd0);
        @(negedge clk); check("lat_e1", 64'(cmd_valid), 64'd0);
        exp_q.push_back({2'b01, 38'h04_0000_1234});
        @(negedge clk); check("lat_e2", 64'(cmd_valid), 64'd1);
        @(negedge clk); vs_udr = 1'b0;
        repeat (4) @(negedge clk);
        check("single_ir",     64'(cmd_ir),     64'd1);
        check("single_data",   64'(cmd_data),   64'h04_0000_1234);
        check("single_action", 64'(cmd_action), 64'd1);
        check("single_level",  64'(level),      64'd1);
        pop_one("single_pop");
        check("single_empty", 64'(cmd_valid), 64'd0);

        // fill and overflow
        for (int i = 1; i <= 5; i++) strobe(1'b0, 1'b1, '0, DR_W'(i), 1'b0);
        check("fill_level", 64'(level), 64'd4);
        check("fill_ovf",   64'(ovf),   64'd1);
        for (int i = 0; i < 4; i++) pop_one("fill_pop");
        check("fill_drained", 64'(level), 64'd0);
        check("fill_ovf_sticky", 64'(ovf), 64'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        model_ovf = 1'b0;
        check("ovf_clr", 64'(ovf), 64'd0);

        // full with concurrent pop
        for (int i = 11; i <= 14; i++) strobe(1'b0, 1'b1, '0, DR_W'(i), 1'b0);
        check("cfull_level_pre", 64'(level), 64'd4);
        strobe(1'b0, 1'b1, '0, DR_W'(15), 1'b1);
        check("cfull_level", 64'(level), 64'd4);
        check("cfull_ovf",   64'(ovf),   64'(model_ovf));
        check("cfull_ovf0",  64'(ovf),   64'd0);
        for (int i = 0; i < 4; i++) pop_one("cfull_pop");
        check("cfull_drained", 64'(level), 64'd0);

        // coincident IR/DR update
        strobe(1'b1, 1'b0, 2'b00, '0, 1'b0);
        strobe(1'b1, 1'b1, 2'b10, 38'h00_0000_002A, 1'b0);
        check("coinc_ir", 64'(cmd_ir), 64'd2);
        pop_one("coinc_pop");

        // wrap-around with cmd_ready toggling
        popped = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) strobe(1'b0, 1'b1, '0, DR_W'(100 + i), 1'b0);
            end
            begin
                for (int c = 0; c < 300 && popped < 10; c++) begin
                    @(negedge clk);
                    cmd_ready = c[0];
                    if (cmd_ready && cmd_valid) begin
                        chk_head("wrap");
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end
                @(negedge clk);
                cmd_ready = 1'b0;
            end
        join
        check("wrap_count", 64'(popped), 64'd10);
        check("wrap_ovf",   64'(ovf),    64'd0);
        check("wrap_level", 64'(level),  64'd0);

        // async reset mid-operation
        for (int i = 1; i <= 5; i++) strobe(1'b0, 1'b1, '0, DR_W'(200 + i), 1'b0);
        pop_one("rst_pre_pop");
        check("rst_pre_level", 64'(level), 64'd3);
        check("rst_pre_ovf",   64'(ovf),   64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(cmd_valid), 64'd0);
        check("arst_level", 64'(level),     64'd0);
        check("arst_ovf",   64'(ovf),       64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        model_ovf = 1'b0;
        model_ir = '0;
        @(negedge clk);
        strobe(1'b0, 1'b1, '0, 38'h3C_0000_0077, 1'b0);
        check("post_rst_level", 64'(level), 64'd1);
        pop_one("post_rst_pop");
        check("post_rst_empty", 64'(level), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
